// File: rtl/onchip_ram_2port_if.sv
// Avalon-MM slave port bundle for onchip_ram_2port; one instance per port.
interface onchip_ram_2port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
);
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_ram_2port.sv
// Two Avalon-MM slave ports sharing one single-port RAM through a round-robin
// arbiter, with byte-lane writes and a 1- or 2-stage pipelined read return.
module onchip_ram_2port #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 13,
  parameter int DEPTH        = 6500,
  parameter int READ_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  input logic               clken,
  onchip_ram_2port_if.slave s1,
  onchip_ram_2port_if.slave s2
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic { GRANT_S1 = 1'b0, GRANT_S2 = 1'b1 } grant_e;

  grant_e                lastGrant_q, lastGrant_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  req1, req2, grant1, grant2, accept1, accept2;
  logic                  selRead, selWrite, inRange;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [NUM_LANES-1:0]  selBe;
  logic [DATA_WIDTH-1:0] selWdata, rdWord;
  logic [IDX_WIDTH-1:0]  memIdx;
  logic [1:0]            readAccept;

  logic [1:0]            valid1_q;
  logic [DATA_WIDTH-1:0] data1_q [2];
  logic [1:0]            outValid;
  logic [DATA_WIDTH-1:0] outData [2];

  // On a tie the port that did not win last time gets the access.
  assign req1   = s1.chipselect & (s1.read | s1.write);
  assign req2   = s2.chipselect & (s2.read | s2.write);
  assign grant1 = req1 & (~req2 | (lastGrant_q == GRANT_S2));
  assign grant2 = req2 & (~req1 | (lastGrant_q == GRANT_S1));

  assign s1.waitrequest = ~clken | (req1 & ~grant1);
  assign s2.waitrequest = ~clken | (req2 & ~grant2);

  assign accept1 = grant1 & clken & ~reset;
  assign accept2 = grant2 & clken & ~reset;

  always_comb begin
    if (accept2) begin
      selAddr  = s2.address;
      selBe    = s2.byteenable;
      selWdata = s2.writedata;
      selRead  = s2.read;
      selWrite = s2.write & ~s2.read;
    end else begin
      selAddr  = s1.address;
      selBe    = s1.byteenable;
      selWdata = s1.writedata;
      selRead  = accept1 & s1.read;
      selWrite = accept1 & s1.write & ~s1.read;
    end
  end

  assign inRange     = ({1'b0, selAddr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign memIdx      = selAddr[IDX_WIDTH-1:0];
  assign rdWord      = inRange ? mem[memIdx] : '0;
  assign readAccept  = {accept2 & selRead, accept1 & selRead};
  assign lastGrant_d = accept1 ? GRANT_S1 : (accept2 ? GRANT_S2 : lastGrant_q);

  // Memory has no reset so its contents survive a system reset.
  always_ff @(posedge clk) begin
    if (selWrite && inRange) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (selBe[k]) mem[memIdx][8*k +: 8] <= selWdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant_q <= GRANT_S2;
      valid1_q    <= '0;
      data1_q[0]  <= '0;
      data1_q[1]  <= '0;
    end else if (clken) begin
      lastGrant_q <= lastGrant_d;
      valid1_q    <= readAccept;
      for (int p = 0; p < 2; p++) begin
        if (readAccept[p]) data1_q[p] <= rdWord;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : gen_lat2
      logic [1:0]            valid2_q;
      logic [DATA_WIDTH-1:0] data2_q [2];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid2_q   <= '0;
          data2_q[0] <= '0;
          data2_q[1] <= '0;
        end else if (clken) begin
          valid2_q   <= valid1_q;
          data2_q[0] <= data1_q[0];
          data2_q[1] <= data1_q[1];
        end
      end

      assign outValid   = valid2_q;
      assign outData[0] = data2_q[0];
      assign outData[1] = data2_q[1];
    end else begin : gen_lat1
      assign outValid   = valid1_q;
      assign outData[0] = data1_q[0];
      assign outData[1] = data1_q[1];
    end
  endgenerate

  assign s1.readdatavalid = outValid[0];
  assign s2.readdatavalid = outValid[1];
  assign s1.readdata      = outData[0];
  assign s2.readdata      = outData[1];
endmodule

// File: tb/tb_onchip_ram_2port.sv
// Bench for onchip_ram_2port: directed vector table, LAT=2 stall/reset
// sequences, and randomized two-port traffic against a transaction-level model.
module tb_onchip_ram_2port;
  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int DEPTH = 6500;

  logic clk = 1'b0;
  logic reset, clken, clken2;

  always #5 clk = ~clk;

  onchip_ram_2port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1If (), s2If (), s1bIf (), s2bIf ();

  onchip_ram_2port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .clken(clken), .s1(s1If), .s2(s2If)
  );

  onchip_ram_2port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .clken(clken2), .s1(s1bIf), .s2(s2bIf)
  );

  typedef struct {
    bit            cs;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            known;
  } pend_t;

  typedef struct {
    bit            onS2;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wd;
    logic [DW-1:0] expData;
  } vec_t;

  // Model: memory as a sparse map of known words, per-port queues of reads
  // with the cycle their result is due, and who won the last access.
  logic [DW-1:0] refMem [int];
  pend_t         pend1[$];
  pend_t         pend2[$];
  bit            lastWasS1;
  int            cycleNo;
  bit            ceCycle;
  bit            expValid [2];
  bit            expKnown [2];
  logic [DW-1:0] expData [2];
  logic          obsWait [2];
  int            pulses [2];
  int            errors;
  int            checks;

  function automatic req_t mkReq(bit rd, bit wr, int addr, logic [3:0] be, logic [DW-1:0] wd);
    req_t r;
    r.cs   = rd | wr;
    r.rd   = rd;
    r.wr   = wr;
    r.addr = AW'(addr);
    r.be   = be;
    r.wd   = wd;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic modelAccess(input int port, input req_t r);
    int a;
    a = int'(r.addr);
    lastWasS1 = (port == 0);
    if (r.rd) begin
      pend_t p;
      p.due   = cycleNo + 1;
      p.known = 1'b1;
      p.data  = '0;
      if (a < DEPTH) begin
        if (refMem.exists(a)) p.data = refMem[a];
        else p.known = 1'b0;
      end
      if (port == 0) pend1.push_back(p);
      else pend2.push_back(p);
    end else if (r.wr && a < DEPTH) begin
      if (refMem.exists(a)) begin
        logic [DW-1:0] w;
        w = refMem[a];
        for (int k = 0; k < 4; k++) begin
          if (r.be[k]) w[8*k +: 8] = r.wd[8*k +: 8];
        end
        refMem[a] = w;
      end else if (r.be == 4'hF) begin
        refMem[a] = r.wd;
      end
    end
  endtask

  task automatic sampleOutputs();
    logic          actV;
    logic [DW-1:0] actD;
    pend_t         p;
    cycleNo++;
    for (int port = 0; port < 2; port++) begin
      actV = (port == 0) ? s1If.readdatavalid : s2If.readdatavalid;
      actD = (port == 0) ? s1If.readdata : s2If.readdata;
      if (reset) begin
        expValid[port] = 1'b0;
        checkOutput($sformatf("s%0d readdata in reset", port + 1), actD, 32'h0);
      end else if (ceCycle) begin
        expValid[port] = 1'b0;
        if (port == 0 && pend1.size() > 0 && pend1[0].due == cycleNo) begin
          p = pend1.pop_front();
          expValid[0] = 1'b1; expData[0] = p.data; expKnown[0] = p.known;
        end else if (port == 1 && pend2.size() > 0 && pend2[0].due == cycleNo) begin
          p = pend2.pop_front();
          expValid[1] = 1'b1; expData[1] = p.data; expKnown[1] = p.known;
        end
      end
      checkOutput($sformatf("s%0d readdatavalid cyc%0d", port + 1, cycleNo), actV, expValid[port]);
      if (actV === 1'b1) pulses[port]++;
      if (!reset && expValid[port] && expKnown[port])
        checkOutput($sformatf("s%0d readdata cyc%0d", port + 1, cycleNo), actD, expData[port]);
    end
  endtask

  // Drives one cycle on the LAT=1 instance and checks it against the model.
  task automatic applyStimulus(input req_t a, input req_t b, input bit ce);
    bit r1, r2;
    int winner;
    s1If.chipselect = a.cs; s1If.read = a.rd; s1If.write = a.wr;
    s1If.address = a.addr; s1If.byteenable = a.be; s1If.writedata = a.wd;
    s2If.chipselect = b.cs; s2If.read = b.rd; s2If.write = b.wr;
    s2If.address = b.addr; s2If.byteenable = b.be; s2If.writedata = b.wd;
    clken = ce;
    @(negedge clk);
    r1 = a.cs & (a.rd | a.wr);
    r2 = b.cs & (b.rd | b.wr);
    if (r1 && r2) winner = lastWasS1 ? 2 : 1;
    else winner = r1 ? 1 : (r2 ? 2 : 0);
    obsWait[0] = s1If.waitrequest;
    obsWait[1] = s2If.waitrequest;
    checkOutput($sformatf("s1 waitrequest cyc%0d", cycleNo), obsWait[0], !ce || (r1 && winner != 1));
    checkOutput($sformatf("s2 waitrequest cyc%0d", cycleNo), obsWait[1], !ce || (r2 && winner != 2));
    if (reset) begin
      pend1.delete();
      pend2.delete();
      lastWasS1 = 1'b0;
    end else if (!ce) begin
      foreach (pend1[i]) pend1[i].due = pend1[i].due + 1;
      foreach (pend2[i]) pend2[i].due = pend2[i].due + 1;
    end else if (winner == 1) begin
      modelAccess(0, a);
    end else if (winner == 2) begin
      modelAccess(1, b);
    end
    ceCycle = ce;
    @(posedge clk);
    #1;
    sampleOutputs();
  endtask

  task automatic driveB(input req_t r);
    s1bIf.chipselect = r.cs; s1bIf.read = r.rd; s1bIf.write = r.wr;
    s1bIf.address = r.addr; s1bIf.byteenable = r.be; s1bIf.writedata = r.wd;
  endtask

  vec_t vecs [18];
  req_t idleReq, vr, ra, rb;

  initial begin
    errors = 0; checks = 0; cycleNo = 0; lastWasS1 = 1'b0; ceCycle = 1'b1;
    pulses[0] = 0; pulses[1] = 0;
    expValid[0] = 1'b0; expValid[1] = 1'b0;
    expKnown[0] = 1'b0; expKnown[1] = 1'b0;
    expData[0] = '0; expData[1] = '0;
    idleReq = mkReq(0, 0, 0, 4'h0, 32'h0);

    vecs[0]  = '{0, 0, 1, 13'd5,    4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 1, 0, 13'd5,    4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{0, 0, 1, 13'd7,    4'hF, 32'h11223344, 32'h0};
    vecs[3]  = '{0, 0, 1, 13'd7,    4'h5, 32'hAABBCCDD, 32'h0};
    vecs[4]  = '{0, 1, 0, 13'd7,    4'h0, 32'h0,        32'h11BB33DD};
    vecs[5]  = '{1, 1, 0, 13'd7,    4'h0, 32'h0,        32'h11BB33DD};
    vecs[6]  = '{1, 1, 0, 13'd6500, 4'h0, 32'h0,        32'h0};
    vecs[7]  = '{0, 0, 1, 13'd8000, 4'hF, 32'h12345678, 32'h0};
    vecs[8]  = '{0, 1, 0, 13'd8000, 4'h0, 32'h0,        32'h0};
    vecs[9]  = '{0, 1, 0, 13'd7,    4'h0, 32'h0,        32'h11BB33DD};
    vecs[10] = '{1, 0, 1, 13'd5,    4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[11] = '{0, 1, 0, 13'd5,    4'h0, 32'h0,        32'hDEADBEEF};
    vecs[12] = '{1, 0, 1, 13'd5,    4'h1, 32'h00000099, 32'h0};
    vecs[13] = '{0, 1, 0, 13'd5,    4'h0, 32'h0,        32'hDEADBE99};
    vecs[14] = '{1, 1, 0, 13'd5,    4'h0, 32'h0,        32'hDEADBE99};
    vecs[15] = '{0, 1, 0, 13'd7,    4'h0, 32'h0,        32'h11BB33DD};
    vecs[16] = '{1, 0, 1, 13'd7,    4'hF, 32'h55667788, 32'h0};
    vecs[17] = '{1, 1, 0, 13'd7,    4'h0, 32'h0,        32'h55667788};

    reset = 1'b1; clken = 1'b1; clken2 = 1'b1;
    s1If.chipselect = 0; s1If.read = 0; s1If.write = 0; s1If.address = '0; s1If.byteenable = '0; s1If.writedata = '0;
    s2If.chipselect = 0; s2If.read = 0; s2If.write = 0; s2If.address = '0; s2If.byteenable = '0; s2If.writedata = '0;
    s2bIf.chipselect = 0; s2bIf.read = 0; s2bIf.write = 0; s2bIf.address = '0; s2bIf.byteenable = '0; s2bIf.writedata = '0;
    driveB(idleReq);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset s1 readdatavalid", s1If.readdatavalid, 1'b0);
    checkOutput("reset s1 readdata", s1If.readdata, 32'h0);
    checkOutput("reset s2 readdatavalid", s2If.readdatavalid, 1'b0);
    checkOutput("reset s2 readdata", s2If.readdata, 32'h0);
    checkOutput("reset lat2 readdatavalid", s1bIf.readdatavalid, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      vr = mkReq(vecs[i].rd, vecs[i].wr, int'(vecs[i].addr), vecs[i].be, vecs[i].wd);
      if (vecs[i].onS2) applyStimulus(idleReq, vr, 1'b1);
      else applyStimulus(vr, idleReq, 1'b1);
      if (vecs[i].rd) begin
        checkOutput($sformatf("vec%0d valid", i), vecs[i].onS2 ? s2If.readdatavalid : s1If.readdatavalid, 1'b1);
        checkOutput($sformatf("vec%0d data", i), vecs[i].onS2 ? s2If.readdata : s1If.readdata, vecs[i].expData);
      end
      if (i < 5) checkOutput($sformatf("vec%0d s2 readdata quiet", i), s2If.readdata, 32'h0);
    end

    driveB(mkReq(0, 1, 9, 4'hF, 32'hCAFEF00D));
    applyStimulus(idleReq, idleReq, 1'b1);
    driveB(mkReq(1, 0, 9, 4'h0, 32'h0));
    applyStimulus(idleReq, idleReq, 1'b1);
    checkOutput("lat2 valid T+1", s1bIf.readdatavalid, 1'b0);
    driveB(idleReq);
    clken2 = 1'b0;
    applyStimulus(idleReq, idleReq, 1'b1);
    checkOutput("lat2 waitrequest clken low", s1bIf.waitrequest, 1'b1);
    checkOutput("lat2 valid T+2 stalled", s1bIf.readdatavalid, 1'b0);
    clken2 = 1'b1;
    applyStimulus(idleReq, idleReq, 1'b1);
    checkOutput("lat2 valid T+3", s1bIf.readdatavalid, 1'b1);
    checkOutput("lat2 data T+3", s1bIf.readdata, 32'hCAFEF00D);
    applyStimulus(idleReq, idleReq, 1'b1);
    checkOutput("lat2 valid T+4", s1bIf.readdatavalid, 1'b0);

    driveB(mkReq(1, 0, 9, 4'h0, 32'h0));
    applyStimulus(idleReq, idleReq, 1'b1);
    reset = 1'b1;
    driveB(idleReq);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) reset = 1'b0;
      applyStimulus(idleReq, idleReq, 1'b1);
      checkOutput($sformatf("lat2 dropped read %0d", i), s1bIf.readdatavalid, 1'b0);
    end
    driveB(mkReq(1, 0, 9, 4'h0, 32'h0));
    applyStimulus(idleReq, idleReq, 1'b1);
    driveB(idleReq);
    applyStimulus(idleReq, idleReq, 1'b1);
    checkOutput("lat2 retained valid", s1bIf.readdatavalid, 1'b1);
    checkOutput("lat2 retained data", s1bIf.readdata, 32'hCAFEF00D);

    pulses[0] = 0; pulses[1] = 0;
    ra = mkReq(1, 0, 5, 4'h0, 32'h0);
    rb = mkReq(1, 0, 7, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(ra, rb, 1'b1);
      checkOutput($sformatf("tie%0d s1 waitrequest", i), obsWait[0], i % 2);
      checkOutput($sformatf("tie%0d s2 waitrequest", i), obsWait[1], 1 - (i % 2));
    end
    repeat (2) applyStimulus(idleReq, idleReq, 1'b1);
    checkOutput("tie s1 pulse count", pulses[0], 4);
    checkOutput("tie s2 pulse count", pulses[1], 4);

    for (int a = 0; a < 16; a++) applyStimulus(mkReq(0, 1, a, 4'hF, $urandom), idleReq, 1'b1);
    for (int n = 0; n < 400; n++) begin
      bit rd1, rd2;
      rd1 = 1'($urandom_range(0, 1));
      rd2 = 1'($urandom_range(0, 1));
      ra = mkReq(rd1, !rd1, ($urandom_range(0, 15) == 0) ? $urandom_range(6500, 8191) : $urandom_range(0, 15),
                 4'($urandom_range(0, 15)), $urandom);
      rb = mkReq(rd2, !rd2, ($urandom_range(0, 15) == 0) ? $urandom_range(6500, 8191) : $urandom_range(0, 15),
                 4'($urandom_range(0, 15)), $urandom);
      ra.cs = ($urandom_range(0, 3) != 0);
      rb.cs = ($urandom_range(0, 3) != 0);
      applyStimulus(ra, rb, $urandom_range(0, 9) != 0);
    end
    repeat (3) applyStimulus(idleReq, idleReq, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/onchip_ram_2port.md
# onchip_ram_2port

Parametrised on-chip RAM with two Avalon-MM slave ports (s1, s2) sharing one inferred single-port memory array through a round-robin arbiter. Configurable width, depth and read latency, with per-byte write enables, waitrequest back-pressure, readdatavalid-qualified pipelined reads, a clock-enable stall and out-of-range address protection. It replaces fixed-geometry single-port on-chip memories on the Nios II system interconnect, where both an instruction master and a data master need a port.

## Interface
- DATA_WIDTH, 32: word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 13: word-address width.
- DEPTH, 6500: number of words. Must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1: cycles from read acceptance to readdatavalid. Legal values are 1 and 2; 2 adds an output register.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  global clock enable; low stalls the whole block.
- sN_chipselect  in  1  port N select (N = 1, 2; the same set of signals exists per port).
- sN_read / sN_write  in  1  read / write strobe. Both high in the same cycle is illegal.
- sN_address  in  ADDR_WIDTH  word address.
- sN_byteenable  in  DATA_WIDTH/8  byte-lane write enables; ignored on reads.
- sN_writedata  in  DATA_WIDTH  write data.
- sN_readdata  out  DATA_WIDTH  read data; valid only while sN_readdatavalid is high.
- sN_readdatavalid  out  1  one-cycle pulse per accepted read.
- sN_waitrequest  out  1  request not accepted this cycle.

## Operation
- A request on port N is (sN_chipselect & (sN_read | sN_write)). It is accepted in the cycle where the request is high, sN_waitrequest is low and clken is high.
- Arbiter:
  - One access per cycle.
  - If only one port requests, that port is granted.
  - If both request, the port not granted last time wins.
  - last_grant updates only on an accepted request; its reset value is s2, so s1 wins the first tie.
- sN_waitrequest is combinational:
  - high when clken = 0 or port N requests and loses arbitration;
  - otherwise low, including when port N is idle.
- Write:
  - Lane k of the addressed word takes writedata[8k+7:8k] when byteenable[k] = 1; other lanes are unchanged.
  - byteenable = 0 is accepted and is a no-op.
- Read: returns the full word on the granting port only, after READ_LATENCY cycles.
- Out-of-range address (address ≥ DEPTH):
  - writes are accepted and discarded;
  - reads are accepted and return all zeros with readdatavalid asserted normally.
- Read pipeline: a per-port valid shift register of length READ_LATENCY, plus a data register per stage when READ_LATENCY = 2.
- clken = 0: the pipeline, last_grant and memory all hold. Outputs keep their values, so a readdatavalid that is high stays high. The master must not consume it twice; the system guarantees clken is tied high whenever the port has pending reads.
- Reset:
  - readdata = 0, readdatavalid = 0, pipeline valids cleared, last_grant = s2.
  - Memory contents are not cleared.
  - Reads in flight when reset asserts are dropped with no readdatavalid.
  - waitrequest follows its combinational rule during reset. The arbiter state is held at its reset value, and accepted writes during reset are suppressed.

## Timing
- Write accepted in cycle T: memory is updated at the end of T. A read accepted at T+1 from either port returns the new data.
- Read accepted in cycle T: sN_readdatavalid is high in cycle T+READ_LATENCY, for exactly one cycle (clken high).
- Back-to-back reads on one port: one accepted per cycle, with readdatavalid in the same order and no bubbles.
- Simultaneous contention: in sustained two-port traffic each port is accepted on alternate cycles.
- Read then write to the same address on different ports in consecutive cycles: the read returns the old data.

## Test plan
- Reset, then s1 writes 0xDEADBEEF to address 5 with byteenable 0xF, then s1 reads address 5 → s1_readdatavalid high one cycle later (LAT=1) with 0xDEADBEEF; s2 outputs stay 0.
- Byte lanes: write 0x11223344 to address 7, then write 0xAABBCCDD with byteenable 0x5, then read → 0x11BB33DD.
- Both ports read every cycle for 8 cycles → grants alternate s1, s2, s1, …; each port sees 4 readdatavalid pulses in order, and waitrequest toggles on the losing port.
- Read address 6500 with DEPTH 6500 → readdata 0, readdatavalid asserted. Write address 8000 → a later read of address 8000 & 0x1FFF still returns 0 and no in-range word changes.
- READ_LATENCY=2 build: read issued in cycle T, with clken low at T+1 → readdatavalid appears at T+3 with the correct data.
- Reset asserted one cycle after a read is accepted → no readdatavalid. After reset release the memory still holds its prior contents, and the first s1/s2 tie is granted to s1.
